// File: rtl/int_ctrl.sv
// Six-source prioritised interrupt controller: per-source edge/level pending, mask,
// and a single-level ASSERT/SERVICE handshake toward the CPU hardware interrupt inputs.
module int_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  src_irq,
   input  logic [1:0]  bus_addr,
   input  logic        bus_we,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic        cpu_ack,
   input  logic        cpu_eret,
   output logic [5:0]  hw_int
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  mask_q, mask_d;
   logic [5:0]  mode_q, mode_d;
   logic [5:0]  pend_q, pend_d;
   logic [5:0]  src_q, src_d;
   logic [5:0]  hw_int_q, hw_int_d;
   logic [2:0]  active_id_q, active_id_d;
   logic        busy_q, busy_d;

   logic [5:0]  elig;
   logic [5:0]  rise;
   logic [5:0]  clr;
   logic [5:0]  active_oh;
   logic [2:0]  sel_id;
   logic        wr_mask, wr_mode, wr_pend;
   logic        ack_take;
   logic        unused_wdata_hi;

   assign unused_wdata_hi = ^bus_wdata[31:6];

   assign wr_mask   = bus_we && (bus_addr == 2'd0);
   assign wr_mode   = bus_we && (bus_addr == 2'd1);
   assign wr_pend   = bus_we && (bus_addr == 2'd2);
   assign elig      = pend_q & mask_q;
   assign rise      = src_irq & ~src_q;
   assign active_oh = 6'b000001 << active_id_q;
   assign ack_take  = (state_q == ASSERT) && cpu_ack;
   assign clr       = (wr_pend ? bus_wdata[5:0] : 6'b0) | (ack_take ? active_oh : 6'b0);
   assign hw_int    = hw_int_q;

   // Ascending scan so the highest eligible index wins.
   always_comb begin
      sel_id = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (elig[i]) sel_id = i[2:0];
      end
   end

   // Level bits track the sampled line; a level->edge MODE write drops the bit, and a
   // same-cycle rising edge always beats any clear.
   always_comb begin
      src_d  = src_irq;
      mask_d = wr_mask ? bus_wdata[5:0] : mask_q;
      mode_d = wr_mode ? bus_wdata[5:0] : mode_q;
      pend_d = pend_q;
      for (int i = 0; i < 6; i++) begin
         if (!mode_q[i]) begin
            pend_d[i] = (wr_mode && bus_wdata[i]) ? rise[i] : src_irq[i];
         end else begin
            pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      active_id_d = active_id_q;
      busy_d      = busy_q;
      hw_int_d    = hw_int_q;
      case (state_q)
         IDLE: begin
            if (|elig) begin
               state_d     = ASSERT;
               active_id_d = sel_id;
               hw_int_d    = 6'b000001 << sel_id;
            end
         end
         ASSERT: begin
            if (cpu_ack) begin
               state_d  = SERVICE;
               hw_int_d = 6'b0;
               busy_d   = 1'b1;
            end else if (!(|(elig & active_oh))) begin
               state_d  = IDLE;
               hw_int_d = 6'b0;
            end
         end
         SERVICE: begin
            hw_int_d = 6'b0;
            if (cpu_eret) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            hw_int_d = 6'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mask_q      <= 6'b0;
         mode_q      <= 6'b0;
         pend_q      <= 6'b0;
         src_q       <= 6'b0;
         hw_int_q    <= 6'b0;
         active_id_q <= 3'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         mode_q      <= mode_d;
         pend_q      <= pend_d;
         src_q       <= src_d;
         hw_int_q    <= hw_int_d;
         active_id_q <= active_id_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      bus_rdata = 32'b0;
      case (bus_addr)
         2'd0:    bus_rdata = {26'b0, mask_q};
         2'd1:    bus_rdata = {26'b0, mode_q};
         2'd2:    bus_rdata = {26'b0, pend_q};
         default: bus_rdata = {26'b0, state_q, active_id_q, busy_q};
      endcase
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset reset (synchronous, active-high); all state SHALL change only on the rising edge of clk.
REQ-002 Port list (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- src_irq, in, 6: device interrupt lines; bit 5 is highest priority.
- bus_addr, in, 2: register select (word offset 0..3).
- bus_we, in, 1: bus write strobe.
- bus_wdata, in, 32: bus write data.
- bus_rdata, out, 32: combinational read data for bus_addr.
- cpu_ack, in, 1: one-cycle pulse; the CPU has entered the exception handler for the asserted interrupt.
- cpu_eret, in, 1: one-cycle pulse; the CPU executed eret and exception level is cleared.
- hw_int, out, 6: registered one-hot request to the coprocessor HW inputs; all zero when idle.

Function
REQ-003 Registers SHALL be mapped as follows:
- 0 MASK: rw, bits[5:0].
- 1 MODE: rw, bits[5:0]; 1 = edge, 0 = level.
- 2 PEND: read; a write of 1 clears the corresponding edge-mode bit.
- 3 STATUS: ro; {26'b0, state[1:0], active_id[2:0], busy}.
Unused bits SHALL read 0.
REQ-004 The block SHALL hold a registered copy src_q of src_irq, updated every cycle.
REQ-005 Edge-mode pending: PEND[i] SHALL be set at the clock edge where src_irq[i]=1 and src_q[i]=0, and SHALL hold until cleared by a bus write of 1 or by cpu_ack on that source.
REQ-006 Level-mode pending: PEND[i] SHALL equal src_irq[i] sampled on the previous edge; bus writes SHALL NOT affect level-mode bits.
REQ-007 When a set and a clear hit the same PEND bit in the same cycle, set SHALL win.
REQ-008 Eligible set E = PEND & MASK. Selection SHALL take the highest set index of E as sel_id (3 bits).
REQ-009 The FSM SHALL have three states, encoded IDLE=0, ASSERT=1, SERVICE=2.
REQ-010 IDLE -> ASSERT when E != 0. On that transition active_id <= sel_id, and hw_int SHALL be one-hot at active_id from the next cycle.
REQ-011 ASSERT -> SERVICE on cpu_ack.
- hw_int <= 0.
- The edge-mode PEND bit of active_id is cleared.
- busy <= 1.
REQ-012 ASSERT -> IDLE (hw_int <= 0) if E[active_id] becomes 0 before cpu_ack (masked or cleared); cpu_ack in that same cycle SHALL take precedence, giving SERVICE.
REQ-013 In ASSERT, a newly eligible higher-priority source SHALL NOT preempt; active_id is fixed until the ASSERT state is left.
REQ-014 SERVICE -> IDLE on cpu_eret, with busy <= 0. No hw_int bit SHALL be asserted during SERVICE; there is no nesting.
REQ-015 cpu_ack outside ASSERT and cpu_eret outside SERVICE SHALL be ignored.
REQ-016 Latency: a source rising at edge k (edge mode, masked in, FSM idle) SHALL have PEND set at edge k and hw_int asserted after edge k+1.
REQ-017 After cpu_eret, a still-eligible source SHALL re-enter ASSERT no earlier than one cycle after returning to IDLE.
REQ-018 Bus writes to MASK and MODE SHALL take effect at the write edge and be visible to selection in the following cycle.
REQ-019 A MODE change from level to edge SHALL clear that PEND bit.
REQ-020 Writes to STATUS SHALL be ignored.

Reset
REQ-021 On reset the following SHALL all return to 0: MASK, MODE, PEND, src_q, active_id, busy, hw_int, and the FSM (IDLE).
REQ-022 Reset SHALL take effect in any state, including mid-ASSERT or mid-SERVICE, with hw_int = 0 from the next cycle.
REQ-023 bus_rdata SHALL read 0 for all offsets immediately after reset.

Verification
REQ-024 MASK=0x3F, MODE=0x3F, pulse src_irq[2] at edge k -> PEND=0x04 at k, hw_int=6'b000100 after k+1, STATUS state=1 and active_id=2.
REQ-025 Sources 1 and 4 go pending together -> hw_int=6'b010000. cpu_ack -> PEND=0x02, hw_int=0, state=2. cpu_eret -> IDLE, then hw_int=6'b000010.
REQ-026 Level mode, src_irq[0] held at 1 -> ack and eret. PEND[0] stays 1 and hw_int=6'b000001 is reasserted. Dropping src_irq[0] in ASSERT before ack -> hw_int=0 two cycles later, state IDLE.
REQ-027 Edge arrival on bit 3 in the same cycle as a bus W1C of PEND bit 3 -> PEND[3]=1 (set wins).
REQ-028 Assert reset during SERVICE with PEND=0x21 -> next cycle all registers 0, hw_int=0, state IDLE.
REQ-029 cpu_ack pulsed in IDLE and cpu_eret pulsed in ASSERT -> no state or PEND change.
